button_debouncer: RTL and testbench

//  Debounces one mechanical push-button for the up/down counter front end.

---
 rtl/button_debouncer_if.sv | 25 ++
 rtl/button_debouncer.sv | 138 +++++++++++++
 tb/tb_button_debouncer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// Signal bundle between the debounce tick/button side and one button_debouncer instance.
// The master drives the tick and raw pin; the slave returns the debounced level and strobes.
interface button_debouncer_if;
    logic sample_tick;
    logic btn_raw;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    modport master (
        output sample_tick,
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  sample_tick,
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/button_debouncer.sv
// Single push-button debouncer: 2-flop synchroniser, tick-sampled 4-state FSM,
// registered level plus one-cycle press/release strobes.
module button_debouncer #(
    parameter int STABLE_SAMPLES = 4,
    parameter int CNT_W          = 3,
    parameter bit ACTIVE_HIGH    = 1'b1
) (
    input logic               clk,
    input logic               rst_a_p,
    button_debouncer_if.slave bus
);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    localparam logic             RAW_IDLE = ACTIVE_HIGH ? 1'b0 : 1'b1;
    // A check completes when the sample about to be counted is the last one needed.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

    logic [1:0]       sync_q;
    logic             btn_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            sync_q <= {2{RAW_IDLE}};
        end else begin
            sync_q <= {sync_q[0], bus.btn_raw};
        end
    end

    assign btn_s = ACTIVE_HIGH ? sync_q[1] : ~sync_q[1];

    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            RELEASED: begin
                if (bus.sample_tick && btn_s) begin
                    if (STABLE_SAMPLES == 1) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        state_d = PRESS_CHK;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end

            PRESS_CHK: begin
                if (bus.sample_tick) begin
                    if (!btn_s) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            PRESSED: begin
                if (bus.sample_tick && !btn_s) begin
                    if (STABLE_SAMPLES == 1) begin
                        state_d   = RELEASED;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        state_d = RELEASE_CHK;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end

            RELEASE_CHK: begin
                if (bus.sample_tick) begin
                    if (btn_s) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = RELEASED;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer; an active-high and an active-low
// instance see the same button (pin inverted for the latter) and share one window-based model.
module tb_button_debouncer;

    localparam int N = 4;

    logic clk;
    logic rst_a_p;

    button_debouncer_if bus_ah ();
    button_debouncer_if bus_al ();

    button_debouncer #(.STABLE_SAMPLES(N), .CNT_W(3), .ACTIVE_HIGH(1'b1)) dut_ah (
        .clk     (clk),
        .rst_a_p (rst_a_p),
        .bus     (bus_ah)
    );

    button_debouncer #(.STABLE_SAMPLES(N), .CNT_W(3), .ACTIVE_HIGH(1'b0)) dut_al (
        .clk     (clk),
        .rst_a_p (rst_a_p),
        .bus     (bus_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: pressed-sense pin delayed two clocks, then the debounced level
    // flips whenever the last N tick samples all disagree with it.
    bit m_s1, m_s2;
    bit m_win[$];
    bit m_level, m_press, m_rel;

    task automatic model_reset();
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        m_win.delete();
        m_level = 1'b0;
        m_press = 1'b0;
        m_rel   = 1'b0;
    endtask

    task automatic model_edge(input bit pressed_pin, input bit tick);
        bit all_differ;
        m_press = 1'b0;
        m_rel   = 1'b0;
        if (tick) begin
            m_win.push_back(m_s2);
            if (m_win.size() > N) void'(m_win.pop_front());
            all_differ = (m_win.size() == N);
            foreach (m_win[i]) if (m_win[i] == m_level) all_differ = 1'b0;
            if (all_differ) begin
                m_level = !m_level;
                if (m_level) m_press = 1'b1;
                else         m_rel   = 1'b1;
            end
        end
        m_s2 = m_s1;
        m_s1 = pressed_pin;
    endtask

    task automatic check_outputs();
        check("ah_level",   bus_ah.btn_level,   m_level);
        check("ah_press",   bus_ah.btn_press,   m_press);
        check("ah_release", bus_ah.btn_release, m_rel);
        check("al_level",   bus_al.btn_level,   m_level);
        check("al_press",   bus_al.btn_press,   m_press);
        check("al_release", bus_al.btn_release, m_rel);
    endtask

    // One clock: drive inputs, take the edge, advance the model, sample 1 time unit later.
    task automatic step(input bit raw, input bit tick);
        bus_ah.btn_raw     = raw;
        bus_al.btn_raw     = ~raw;
        bus_ah.sample_tick = tick;
        bus_al.sample_tick = tick;
        @(posedge clk);
        model_edge(raw, tick);
        #1;
        check_outputs();
        cyc++;
    endtask

    task automatic run(input int ncyc, input bit raw, input int period);
        for (int i = 0; i < ncyc; i++) step(raw, (cyc % period) == (period - 1));
    endtask

    task automatic do_reset(input bit raw);
        bus_ah.btn_raw = raw;
        bus_al.btn_raw = ~raw;
        rst_a_p = 1'b1;
        #1;
        check("rst_ah_level",   bus_ah.btn_level,   1'b0);
        check("rst_ah_press",   bus_ah.btn_press,   1'b0);
        check("rst_ah_release", bus_ah.btn_release, 1'b0);
        check("rst_al_level",   bus_al.btn_level,   1'b0);
        check("rst_al_press",   bus_al.btn_press,   1'b0);
        check("rst_al_release", bus_al.btn_release, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_a_p = 1'b0;
    endtask

    initial begin
        int lat;
        bit raw;
        int period;
        int hold;
        bit bouncy;

        rst_a_p            = 1'b1;
        bus_ah.btn_raw     = 1'b0;
        bus_al.btn_raw     = 1'b1;
        bus_ah.sample_tick = 1'b0;
        bus_al.sample_tick = 1'b0;
        model_reset();
        #3;
        do_reset(1'b0);

        // Idle button: 20 ticks, never a strobe.
        run(200, 1'b0, 10);
        // Clean press, then a press with bounce across the first ticks.
        run(60, 1'b1, 10);
        check("press_level", bus_ah.btn_level, 1'b1);
        run(60, 1'b0, 10);
        run(10, 1'b1, 10);
        run(10, 1'b0, 10);
        run(10, 1'b1, 10);
        run(60, 1'b1, 10);
        // Release from PRESSED.
        run(60, 1'b0, 10);
        check("release_level", bus_ah.btn_level, 1'b0);
        // Reset in the middle of a press check, button still held afterwards.
        run(35, 1'b1, 10);
        do_reset(1'b1);
        run(60, 1'b1, 10);
        check("post_reset_level", bus_ah.btn_level, 1'b1);
        run(60, 1'b0, 10);

        // Tick tied high: press strobe 6 clk after the raw edge.
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            step(1'b1, 1'b1);
            if (bus_ah.btn_press && bus_al.btn_press) lat = i;
        end
        check("tick_high_latency", lat, 6);
        run(20, 1'b1, 1);
        run(20, 1'b0, 1);

        // Random pins, holds, bounce bursts, tick periods and occasional resets.
        for (int k = 0; k < 300; k++) begin
            raw    = 1'($urandom);
            period = $urandom_range(1, 12);
            hold   = $urandom_range(1, 50);
            bouncy = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) do_reset(raw);
            for (int i = 0; i < hold; i++) begin
                if (bouncy) raw = 1'($urandom);
                step(raw, (cyc % period) == (period - 1));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
